// File: rtl/fetch_debug_controller.sv
// Debug sequencer for the pipeline front end: assembles UART bytes into
// instruction words, loads them into IMEM, then gates free-run/single-step execution.
module fetch_debug_controller #(
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
    parameter logic [7:0]  CMD_LOAD  = 8'h4C,
    parameter logic [7:0]  CMD_RUN   = 8'h52,
    parameter logic [7:0]  CMD_STEP  = 8'h53,
    parameter int          ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              inHalt,
    output logic              wr_instruction,
    output logic [31:0]       data_instruction,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              pipe_enable,
    output logic              stopPC_debug,
    output logic [31:0]       cycle_count,
    output logic [ADDR_W-1:0] load_count,
    output logic              done,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT_CMD, RUN, STEP_PULSE, STEP_WAIT, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state, state_nxt;
    logic [1:0]        byte_cnt, byte_cnt_nxt;
    logic [23:0]       shift, shift_nxt;
    logic [31:0]       word;
    logic              wr_nxt, pe_nxt, clear;
    logic [31:0]       data_nxt;
    logic [ADDR_W-1:0] addr_nxt, lc_nxt;

    // Only three bytes need holding; the fourth is taken straight from rx_data.
    assign word = {shift, rx_data};

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        shift_nxt    = shift;
        wr_nxt       = 1'b0;
        data_nxt     = data_instruction;
        addr_nxt     = wr_addr;
        lc_nxt       = load_count;
        pe_nxt       = 1'b0;
        clear        = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (rx_valid && rx_data == CMD_LOAD) begin
                    state_nxt    = LOAD;
                    clear        = 1'b1;
                    lc_nxt       = '0;
                    addr_nxt     = '0;
                    byte_cnt_nxt = '0;
                    shift_nxt    = '0;
                end
            end
            LOAD: begin
                if (rx_valid) begin
                    byte_cnt_nxt = byte_cnt + 2'd1;
                    shift_nxt    = {shift[15:0], rx_data};
                    if (byte_cnt == 2'd3) begin
                        wr_nxt   = 1'b1;
                        data_nxt = word;
                        addr_nxt = load_count;
                        // Saturate at the last address so a full memory never wraps.
                        if (load_count != ADDR_MAX)
                            lc_nxt = load_count + ADDR_W'(1);
                        if (word == HALT_WORD || load_count == ADDR_MAX)
                            state_nxt = WAIT_CMD;
                    end
                end
            end
            WAIT_CMD: begin
                if (rx_valid && rx_data == CMD_RUN) begin
                    state_nxt = RUN;
                    pe_nxt    = 1'b1;
                end else if (rx_valid && rx_data == CMD_STEP) begin
                    state_nxt = STEP_PULSE;
                    pe_nxt    = 1'b1;
                end
            end
            RUN: begin
                if (inHalt) state_nxt = DONE;
                else        pe_nxt    = 1'b1;
            end
            STEP_PULSE: state_nxt = STEP_WAIT;
            STEP_WAIT: begin
                if (inHalt) begin
                    state_nxt = DONE;
                end else if (rx_valid && rx_data == CMD_STEP) begin
                    state_nxt = STEP_PULSE;
                    pe_nxt    = 1'b1;
                end else if (rx_valid && rx_data == CMD_RUN) begin
                    state_nxt = RUN;
                    pe_nxt    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            byte_cnt         <= '0;
            shift            <= '0;
            wr_instruction   <= 1'b0;
            data_instruction <= '0;
            wr_addr          <= '0;
            load_count       <= '0;
            pipe_enable      <= 1'b0;
            stopPC_debug     <= 1'b1;
            cycle_count      <= '0;
            done             <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_nxt;
            byte_cnt         <= byte_cnt_nxt;
            shift            <= shift_nxt;
            wr_instruction   <= wr_nxt;
            data_instruction <= data_nxt;
            wr_addr          <= addr_nxt;
            load_count       <= lc_nxt;
            pipe_enable      <= pe_nxt;
            stopPC_debug     <= ~pe_nxt;
            cycle_count      <= clear ? 32'd0 : cycle_count + 32'(pipe_enable);
            done             <= (state_nxt == DONE);
            busy             <= (state_nxt inside {LOAD, RUN, STEP_PULSE});
        end
    end

endmodule

// File: tb/tb_fetch_debug_controller.sv
// Directed bench for fetch_debug_controller: load, run, step, mid-load reset, reload.
module tb_fetch_debug_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        inHalt = 1'b0;
    logic        wr_instruction;
    logic [31:0] data_instruction;
    logic [9:0]  wr_addr;
    logic        pipe_enable;
    logic        stopPC_debug;
    logic [31:0] cycle_count;
    logic [9:0]  load_count;
    logic        done;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Write log and pipe-enable activity, observed on the falling edge.
    logic [31:0] wlog_data[$];
    logic [31:0] wlog_addr[$];
    int          pe_cycles = 0;
    int          overlap = 0;

    fetch_debug_controller dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .inHalt(inHalt),
        .wr_instruction(wr_instruction), .data_instruction(data_instruction),
        .wr_addr(wr_addr), .pipe_enable(pipe_enable), .stopPC_debug(stopPC_debug),
        .cycle_count(cycle_count), .load_count(load_count), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_instruction) begin
                wlog_data.push_back(data_instruction);
                wlog_addr.push_back(32'(wr_addr));
            end
            if (pipe_enable) pe_cycles++;
            if (wr_instruction && pipe_enable) overlap++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Loads two words: w0 then HALT_WORD.
    task automatic load_prog(input logic [31:0] w0);
        send(8'h4C);
        for (int i = 3; i >= 0; i--) send(w0[i*8 +: 8]);
        for (int i = 0; i < 4; i++) send(8'hFF);
        idle(3);
    endtask

    initial begin
        int base;
        int pe0;

        // Reset
        idle(2);
        @(negedge clk);
        chk("rst_pipe_enable", 32'(pipe_enable), 0);
        chk("rst_stopPC", 32'(stopPC_debug), 1);
        chk("rst_wr", 32'(wr_instruction), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_load_count", 32'(load_count), 0);
        rst = 1'b0;

        // Load 12345678 then halt word
        base = wlog_data.size();
        send(8'h4C);
        @(negedge clk);
        chk("load_busy", 32'(busy), 1);
        foreach (wlog_data[i]) ;
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
        idle(3);
        chk("load_nwrites", 32'(wlog_data.size() - base), 2);
        if (wlog_data.size() - base == 2) begin
            chk("load_w0_data", wlog_data[base], 32'h12345678);
            chk("load_w0_addr", wlog_addr[base], 0);
            chk("load_w1_data", wlog_data[base+1], 32'hFFFFFFFF);
            chk("load_w1_addr", wlog_addr[base+1], 1);
        end
        chk("load_count", 32'(load_count), 2);
        chk("load_no_pe", 32'(pe_cycles), 0);
        chk("wait_busy", 32'(busy), 0);

        // Run, halt sampled on the 6th edge after pipe_enable rises
        pe0 = pe_cycles;
        send(8'h52);
        chk("run_pe", 32'(pipe_enable), 1);
        chk("run_stopPC", 32'(stopPC_debug), 0);
        chk("run_busy", 32'(busy), 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        inHalt = 1'b1;
        @(posedge clk);
        #1;
        inHalt = 1'b0;
        idle(3);
        chk("run_pe_cycles", 32'(pe_cycles - pe0), 6);
        chk("run_cycle_count", cycle_count, 6);
        chk("run_done", 32'(done), 1);
        chk("run_pe_off", 32'(pipe_enable), 0);
        send(8'h52); send(8'h53);
        idle(4);
        chk("done_ignores_pe", 32'(pe_cycles - pe0), 6);
        chk("done_hold", 32'(done), 1);

        // Reload from DONE
        base = wlog_data.size();
        send(8'h4C);
        @(negedge clk);
        chk("reload_done", 32'(done), 0);
        chk("reload_cycle_count", cycle_count, 0);
        chk("reload_load_count", 32'(load_count), 0);
        for (int i = 3; i >= 0; i--) send(8'(32'hCAFEBABE >> (i*8)));
        for (int i = 0; i < 4; i++) send(8'hFF);
        idle(3);
        chk("reload_nwrites", 32'(wlog_data.size() - base), 2);
        if (wlog_data.size() > base) begin
            chk("reload_w0_data", wlog_data[base], 32'hCAFEBABE);
            chk("reload_w0_addr", wlog_addr[base], 0);
        end

        // Single step x3, then step coincident with halt
        pe0 = pe_cycles;
        for (int k = 0; k < 3; k++) begin
            send(8'h53);
            idle(9);
        end
        chk("step_pe_cycles", 32'(pe_cycles - pe0), 3);
        chk("step_cycle_count", cycle_count, 3);
        chk("step_not_done", 32'(done), 0);
        @(negedge clk);
        rx_data  = 8'h53;
        rx_valid = 1'b1;
        inHalt   = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        inHalt   = 1'b0;
        idle(4);
        chk("step_halt_no_pulse", 32'(pe_cycles - pe0), 3);
        chk("step_halt_done", 32'(done), 1);

        // Reset in the middle of a load discards the partial word
        base = wlog_data.size();
        send(8'h4C); send(8'hAA); send(8'hBB);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        idle(2);
        chk("midrst_nowrite", 32'(wlog_data.size() - base), 0);
        load_prog(32'h00000001);
        chk("midrst_nwrites", 32'(wlog_data.size() - base), 2);
        if (wlog_data.size() > base) begin
            chk("midrst_w0_data", wlog_data[base], 32'h00000001);
            chk("midrst_w0_addr", wlog_addr[base], 0);
        end
        chk("midrst_load_count", 32'(load_count), 2);

        chk("wr_pe_overlap", 32'(overlap), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_debug_controller.md
Name: fetch_debug_controller

Overview:
- Debug sequencer for the TP4 pipeline front end.
- Consumes command/data bytes from the UART receiver and assembles 32-bit words, which it writes into instruction memory through the fetch stage's write port.
- Gates pipeline advance through the stop/enable controls, giving free-run or single-step execution until the halt instruction retires.
- Sits between the UART RX and the InstructionFetch / pipeline-enable inputs.

Parameters:
- HALT_WORD, 32'hFFFFFFFF, instruction word that terminates loading and marks program end.
- CMD_LOAD, 8'h4C, byte that starts a program load.
- CMD_RUN, 8'h52, byte that starts continuous execution.
- CMD_STEP, 8'h53, byte that advances the pipeline one clock.
- ADDR_W, 10, width of instruction write address.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- inHalt  in  1  pipeline reports HALT_WORD reached writeback; level, sampled on posedge.
- wr_instruction  out  1  one-cycle instruction-memory write strobe.
- data_instruction  out  32  word to write.
- wr_addr  out  ADDR_W  write address, equals words written so far.
- pipe_enable  out  1  pipeline advance enable (drives PC / IF-ID write).
- stopPC_debug  out  1  always ~pipe_enable.
- cycle_count  out  32  clocks for which pipe_enable was 1 since last load.
- load_count  out  ADDR_W  words written in last/current load.
- done  out  1  halt reached, execution finished.
- busy  out  1  high in LOAD, RUN, STEP_PULSE.

Behaviour:
- Reset is synchronous, active-high. Next posedge with rst=1 forces: state IDLE, all outputs 0 except stopPC_debug=1; byte counter and partial word cleared.
- Reset applies mid-load and mid-run; a partial word is discarded and no write is issued.
- All outputs are registered.
- States:
  - IDLE: CMD_LOAD byte goes to LOAD and clears load_count, wr_addr, cycle_count and done. Other bytes are ignored.
  - LOAD: every rx_valid byte is data; no command parsing.
    - Bytes are shifted in MSB-first: the first byte lands in [31:24].
    - A 2-bit byte counter wraps after 4.
    - On the 4th byte the next cycle has wr_instruction=1, data_instruction=word, wr_addr=load_count; load_count then increments.
    - If the word equals HALT_WORD, it is still written, then the block goes to WAIT_CMD.
    - If load_count reaches 2^ADDR_W-1 and that word is written, the block goes to WAIT_CMD (memory full; no wrap).
  - WAIT_CMD: CMD_RUN goes to RUN. CMD_STEP goes to STEP_PULSE. Other bytes are ignored.
  - RUN: pipe_enable=1 starting the cycle after the CMD_RUN strobe. When inHalt=1 is sampled, pipe_enable=0 next cycle and the block goes to DONE. Bytes are ignored.
  - STEP_PULSE: pipe_enable=1 for exactly one cycle, then STEP_WAIT.
  - STEP_WAIT: CMD_STEP goes to STEP_PULSE. CMD_RUN goes to RUN. inHalt=1 goes to DONE, taking priority over a simultaneous byte.
  - DONE: done=1, pipe_enable=0. CMD_LOAD goes to LOAD (same clearing as from IDLE). Other bytes are ignored.
- cycle_count increments on every posedge where pipe_enable=1. It wraps modulo 2^32.
- wr_instruction and pipe_enable are never high in the same cycle.
- rx_valid arriving on the same cycle as a state change is consumed by the current state only.

Test Plan:
- Reset: hold rst 2 cycles -> pipe_enable=0, stopPC_debug=1, wr_instruction=0, done=0, busy=0, load_count=0.
- Load: bytes 4C,12,34,56,78,FF,FF,FF,FF -> two single-cycle writes: 0x12345678@addr0, then 0xFFFFFFFF@addr1; load_count=2; state WAIT_CMD; pipe_enable stays 0.
- Run: after load, byte 52, inHalt raised 6 cycles after pipe_enable rises -> pipe_enable high exactly 6 cycles, cycle_count=6, done=1, later bytes 52/53 ignored.
- Step: after load, bytes 53,53,53 spaced 10 cycles apart -> three one-cycle pipe_enable pulses, cycle_count=3. Then byte 53 together with inHalt=1 in STEP_WAIT -> DONE, no 4th pulse.
- Reset mid-load: 4C,AA,BB then rst -> no wr_instruction, IDLE. Then 4C,00,00,00,01,FF,FF,FF,FF -> first write 0x00000001@addr0.
- Reload from DONE: byte 4C -> done=0, cycle_count=0, next word written at addr0.
